// File: rtl/mul_seq.sv
// Sequential shift-add multiplier for the Beta ALU MUL op.
// Steps the ALU's shared adder once per cycle for W cycles and returns the low W product bits.
module mul_seq #(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic         busy,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_ci,
    input  logic [W-1:0] add_s
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        r_state;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplr;
    logic [CW-1:0] r_cnt;

    logic          w_last;

    assign w_last = (r_cnt == CW'(W - 1));

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign out_p     = r_acc;
    assign add_a     = r_acc;
    // Partial product is gated so the shared adder sees zero outside RUN.
    assign add_b     = ((r_state == StRun) && r_mplr[0]) ? r_mcand : '0;
    assign add_ci    = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_acc   <= '0;
                        r_mcand <= in_a;
                        r_mplr  <= in_b;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    // Fixed W iterations: no early exit when the multiplier runs out of ones.
                    r_acc   <= add_s;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes expected products, a monitor pops on handshake.
module tb_mul_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p;
    logic         busy;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_ci;
    logic [W-1:0] add_s;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    mul_seq #(.W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s)
    );

    // Stand-in for the ALU's shared adder, carry-out dropped.
    assign add_s = add_a + add_b + W'(add_ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'(0));
            end else begin
                chk("out_p", out_p, exp_q.pop_front());
            end
        end
    end

    // mode: 0 normal, 1 backpressure in DONE, 2 in_valid pulse during RUN, 3 reset mid-RUN
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int mode);
        int waited;
        logic [31:0] m_acc;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'(1));
        if (mode == 1) out_ready = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        if (mode != 3) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        m_acc    = '0;
        for (int k = 0; k < W; k++) begin
            chk("run_busy", 32'(busy), 32'(1));
            chk("run_in_ready", 32'(in_ready), 32'(0));
            chk("run_out_valid", 32'(out_valid), 32'(0));
            chk("run_add_ci", 32'(add_ci), 32'(0));
            chk("run_add_a", add_a, m_acc);
            chk("run_add_b", add_b, b[k] ? (a << k) : 32'(0));
            if (mode == 3 && k == 10) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_out_valid", 32'(out_valid), 32'(0));
                chk("rst_in_ready", 32'(in_ready), 32'(1));
                chk("rst_add_b", add_b, 32'(0));
                chk("rst_out_p", out_p, 32'(0));
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk); #1;
                chk("post_rst_idle", 32'(busy), 32'(0));
                return;
            end
            if (mode == 2 && k == 5) in_valid = 1'b1;
            if (mode == 2 && k == 7) in_valid = 1'b0;
            if (b[k]) m_acc = m_acc + (a << k);
            @(posedge clk); #1;
        end
        chk("latency_out_valid", 32'(out_valid), 32'(1));
        chk("done_out_p", out_p, exp);
        if (mode == 1) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk("hold_out_valid", 32'(out_valid), 32'(1));
                chk("hold_out_p", out_p, exp);
                chk("hold_in_ready", 32'(in_ready), 32'(0));
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'(1));
        chk("release_out_valid", 32'(out_valid), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_out_p", out_p, 32'(0));
        chk("reset_add_a", add_a, 32'(0));
        chk("reset_add_b", add_b, 32'(0));
        chk("reset_add_ci", 32'(add_ci), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 0);
        run_op(32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 0);
        run_op(32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0);
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 0);
        run_op(32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1);
        run_op(32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 2);
        run_op(32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_0000, 3);
        run_op(32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
